// File: rtl/vga_pkg.sv
// Shared definitions for the VGA line fetcher: fetch FSM states, VGA output
// stage codes and bus arbiter client codes.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  localparam logic [1:0] VGA_INACTIVE = 2'd0;
  localparam logic [1:0] VGA_PRE      = 2'd1;
  localparam logic [1:0] VGA_ACTIVE   = 2'd2;

  localparam logic [1:0] CLIENT_CPU  = 2'd0;
  localparam logic [1:0] CLIENT_VGA  = 2'd1;
  localparam logic [1:0] CLIENT_UART = 2'd2;

endpackage

// File: rtl/vga_line_buf.sv
// One display line of frame-buffer words: synchronous write port filled by
// the fetch engine, combinational read port serving pixel requests.
module vga_line_buf #(
  parameter int LINE_WORDS = 4,
  parameter int AW         = $clog2(LINE_WORDS)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [LINE_WORDS];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < LINE_WORDS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/vga_line_fetcher.sv
// Prefetches one display line from SRAM over Wishbone into a local buffer and
// answers VGA pixel-word requests from it with zero added latency.
module vga_line_fetcher
  import vga_pkg::*;
#(
  parameter logic [31:0] BASE_WORD_ADDR = 32'h0000_3E80,
  parameter int          LINE_WORDS     = 4,
  parameter int          NUM_LINES      = 96,
  parameter logic [1:0]  CLIENT_ID      = CLIENT_VGA,
  parameter logic [7:0]  TIMEOUT        = 8'd255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  vga_state,
  input  logic        vga_data_en,
  input  logic [31:0] vga_word_addr,
  input  logic [3:0]  vga_byte_sel,
  output logic [31:0] vga_data,
  output logic        vga_busy,
  input  logic [1:0]  current_client,
  output logic        bus_req,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        fetch_err
);

  localparam int              AW          = $clog2(LINE_WORDS);
  localparam int              TW          = $clog2(NUM_LINES);
  localparam logic [31:0]     NUM_LINES_W = 32'(NUM_LINES);
  localparam logic [TW-1:0]   LAST_LINE   = TW'(NUM_LINES - 1);
  localparam logic [AW-1:0]   LAST_WORD   = AW'(LINE_WORDS - 1);

  fetch_state_t  r_state, w_nextState;
  logic [TW-1:0] r_lineTag, r_target, r_nextLine, w_trigTarget;
  logic          r_lineValid, r_fetchErr, r_prevEn;
  logic [1:0]    r_prevState;
  logic [AW-1:0] r_count;
  logic [7:0]    r_timer;

  logic [31:0]   w_offset, w_lineIdx, w_bufData;
  logic          w_inRange, w_selOk, w_hit, w_demand;
  logic          w_preEdge, w_enFall, w_trigger, w_granted, w_bufWe;

  // Out-of-window addresses (below base or past the last line) never hit and never fetch.
  assign w_offset  = vga_word_addr - BASE_WORD_ADDR;
  assign w_lineIdx = w_offset >> AW;
  assign w_inRange = (vga_word_addr >= BASE_WORD_ADDR) && (w_lineIdx < NUM_LINES_W);
  assign w_selOk   = (vga_byte_sel == 4'hF);
  assign w_hit     = vga_data_en && w_selOk && r_lineValid && w_inRange &&
                     (w_lineIdx == 32'(r_lineTag));

  assign vga_data  = w_hit ? w_bufData : '0;
  assign vga_busy  = vga_data_en && !w_hit;

  assign w_demand  = vga_data_en && !w_hit && w_selOk && w_inRange;
  assign w_preEdge = (vga_state == VGA_PRE) && (r_prevState != VGA_PRE);
  assign w_enFall  = r_prevEn && !vga_data_en && (vga_state == VGA_ACTIVE);
  assign w_trigger = w_preEdge || w_demand || w_enFall;
  assign w_granted = (current_client == CLIENT_ID);
  assign w_bufWe   = (r_state == READ) && w_granted && wb_ack_i;
  assign wb_we_o   = 1'b0;
  assign fetch_err = r_fetchErr;

  always_comb begin
    w_trigTarget = r_nextLine;
    if (w_preEdge)     w_trigTarget = '0;
    else if (w_demand) w_trigTarget = w_lineIdx[TW-1:0];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Losing the grant drops the bus in the same cycle; the word counter is kept so the fetch resumes.
  always_comb begin
    w_nextState = r_state;
    bus_req     = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_adr_o    = '0;
    wb_sel_o    = '0;
    case (r_state)
      IDLE: if (w_trigger) w_nextState = REQ;
      REQ: begin
        bus_req = 1'b1;
        if (w_granted) w_nextState = READ;
      end
      READ: begin
        bus_req = 1'b1;
        if (!w_granted) begin
          w_nextState = REQ;
        end else begin
          wb_cyc_o = 1'b1;
          wb_stb_o = 1'b1;
          wb_sel_o = 4'hF;
          wb_adr_o = BASE_WORD_ADDR + (32'(r_target) << AW) + 32'(r_count);
          if (wb_ack_i) begin
            if (r_count == LAST_WORD) w_nextState = DONE;
          end else if (r_timer == TIMEOUT) begin
            w_nextState = IDLE;
          end
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_lineTag   <= '0;
      r_target    <= '0;
      r_nextLine  <= '0;
      r_lineValid <= 1'b0;
      r_fetchErr  <= 1'b0;
      r_prevEn    <= 1'b0;
      r_prevState <= VGA_INACTIVE;
      r_count     <= '0;
      r_timer     <= '0;
    end else begin
      r_prevState <= vga_state;
      r_prevEn    <= vga_data_en;
      case (r_state)
        IDLE: if (w_trigger) begin
          r_target    <= w_trigTarget;
          r_count     <= '0;
          r_lineValid <= 1'b0;
          if (w_preEdge) begin
            r_nextLine <= '0;
            r_fetchErr <= 1'b0;
          end
        end
        REQ: r_timer <= '0;
        READ: if (w_granted) begin
          if (wb_ack_i) begin
            r_count <= r_count + 1'b1;
            r_timer <= '0;
          end else if (r_timer == TIMEOUT) begin
            r_fetchErr  <= 1'b1;
            r_lineValid <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DONE: begin
          r_lineTag   <= r_target;
          r_lineValid <= 1'b1;
          r_nextLine  <= (r_target == LAST_LINE) ? '0 : r_target + 1'b1;
        end
        default: ;
      endcase
    end
  end

  vga_line_buf #(.LINE_WORDS(LINE_WORDS)) u_buf (
    .clk    (clk),
    .nrst   (nrst),
    .i_we   (w_bufWe),
    .i_waddr(r_count),
    .i_wdata(wb_dat_i),
    .i_raddr(w_offset[AW-1:0]),
    .o_rdata(w_bufData)
  );

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Directed bench for vga_line_fetcher: frame-start fetch, hits, prefetch,
// demand miss, grant loss, timeout, out-of-range requests, wrap, async reset.
module tb_vga_line_fetcher;
  import vga_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_3E80;

  logic        clk, nrst;
  logic [1:0]  vga_state;
  logic        vga_data_en;
  logic [31:0] vga_word_addr;
  logic [3:0]  vga_byte_sel;
  logic [31:0] vga_data;
  logic        vga_busy;
  logic [1:0]  current_client;
  logic        bus_req, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        fetch_err;
  logic        ackEn;

  int testsRun    = 0;
  int testsFailed = 0;

  vga_line_fetcher dut (
    .clk           (clk),
    .nrst          (nrst),
    .vga_state     (vga_state),
    .vga_data_en   (vga_data_en),
    .vga_word_addr (vga_word_addr),
    .vga_byte_sel  (vga_byte_sel),
    .vga_data      (vga_data),
    .vga_busy      (vga_busy),
    .current_client(current_client),
    .bus_req       (bus_req),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_adr_o      (wb_adr_o),
    .wb_sel_o      (wb_sel_o),
    .wb_dat_i      (wb_dat_i),
    .wb_ack_i      (wb_ack_i),
    .fetch_err     (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM slave: single-cycle ack while granted, data word = 0xA0 + word offset from base.
  assign wb_ack_i = ackEn && wb_stb_o && (current_client == CLIENT_VGA);
  assign wb_dat_i = 32'hA0 + (wb_adr_o - BASE);

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] st, input logic en, input logic [31:0] addr);
    vga_state     = st;
    vga_data_en   = en;
    vga_word_addr = addr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data"}, vga_data, 32'd0);
    checkBit({tag, "_busy"}, vga_busy, 1'b0);
    checkBit({tag, "_busreq"}, bus_req, 1'b0);
    checkBit({tag, "_cyc"}, wb_cyc_o, 1'b0);
    checkBit({tag, "_stb"}, wb_stb_o, 1'b0);
    checkBit({tag, "_we"}, wb_we_o, 1'b0);
    checkOutput({tag, "_adr"}, wb_adr_o, 32'd0);
    checkOutput({tag, "_sel"}, {28'd0, wb_sel_o}, 32'd0);
    checkBit({tag, "_err"}, fetch_err, 1'b0);
  endtask

  // Waits (bounded) for the strobe, checks the four word addresses, ends in DONE.
  task automatic expectLine(input string tag, input int line);
    int n = 0;
    while (wb_stb_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    for (int w = 0; w < 4; w++) begin
      checkOutput($sformatf("%s_adr%0d", tag, w), wb_adr_o, BASE + 32'(line * 4 + w));
      checkOutput($sformatf("%s_sel%0d", tag, w), {28'd0, wb_sel_o}, 32'hF);
      tick();
    end
    checkBit({tag, "_done_cyc"}, wb_cyc_o, 1'b0);
    checkBit({tag, "_done_busreq"}, bus_req, 1'b0);
  endtask

  task automatic doReset();
    nrst           = 1'b0;
    vga_byte_sel   = 4'hF;
    current_client = CLIENT_VGA;
    ackEn          = 1'b1;
    applyStimulus(VGA_INACTIVE, 1'b0, 32'd0);
    #10;
    @(negedge clk);
    nrst = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    nrst           = 1'b0;
    vga_byte_sel   = 4'hF;
    current_client = CLIENT_VGA;
    ackEn          = 1'b1;
    applyStimulus(VGA_INACTIVE, 1'b0, 32'd0);
    #3;
    checkAllZero("reset");
    doReset();

    // Frame start fetches line 0 with immediate grant and back-to-back acks
    applyStimulus(VGA_PRE, 1'b0, 32'd0);
    tick();
    checkBit("pre_busreq", bus_req, 1'b1);
    checkBit("pre_cyc", wb_cyc_o, 1'b0);
    expectLine("l0", 0);
    tick();
    applyStimulus(VGA_PRE, 1'b1, BASE + 32'd2);
    checkOutput("l0_hit_data", vga_data, 32'hA2);
    checkBit("l0_hit_busy", vga_busy, 1'b0);

    // Falling data_en during active display prefetches line 1
    applyStimulus(VGA_ACTIVE, 1'b1, BASE + 32'd1);
    checkOutput("l0_hit1_data", vga_data, 32'hA1);
    tick();
    applyStimulus(VGA_ACTIVE, 1'b0, BASE + 32'd1);
    tick();
    checkBit("fall_busreq", bus_req, 1'b1);
    expectLine("l1", 1);
    tick();
    applyStimulus(VGA_ACTIVE, 1'b1, BASE + 32'd5);
    checkOutput("l1_hit_data", vga_data, 32'hA5);
    checkBit("l1_hit_busy", vga_busy, 1'b0);

    // Cold-buffer demand miss on line 2
    doReset();
    applyStimulus(VGA_INACTIVE, 1'b1, BASE + 32'd9);
    checkBit("miss_busy", vga_busy, 1'b1);
    checkOutput("miss_data", vga_data, 32'd0);
    tick();
    expectLine("l2", 2);
    checkBit("l2_done_busy", vga_busy, 1'b1);
    tick();
    checkBit("l2_after_busy", vga_busy, 1'b0);
    checkOutput("l2_after_data", vga_data, 32'hA9);

    // Grant withdrawn after the second ack, restored five cycles later
    doReset();
    applyStimulus(VGA_PRE, 1'b0, 32'd0);
    tick();
    tick();
    checkOutput("gl_adr0", wb_adr_o, BASE);
    tick();
    tick();
    checkOutput("gl_adr2_pre", wb_adr_o, BASE + 32'd2);
    current_client = CLIENT_CPU;
    #1;
    checkBit("gl_drop_cyc", wb_cyc_o, 1'b0);
    tick();
    checkBit("gl_req_busreq", bus_req, 1'b1);
    checkBit("gl_req_stb", wb_stb_o, 1'b0);
    repeat (4) tick();
    current_client = CLIENT_VGA;
    tick();
    checkOutput("gl_resume_adr2", wb_adr_o, BASE + 32'd2);
    tick();
    checkOutput("gl_resume_adr3", wb_adr_o, BASE + 32'd3);
    tick();
    tick();
    applyStimulus(VGA_PRE, 1'b1, BASE);
    checkOutput("gl_word0", vga_data, 32'hA0);
    applyStimulus(VGA_PRE, 1'b1, BASE + 32'd1);
    checkOutput("gl_word1", vga_data, 32'hA1);
    applyStimulus(VGA_PRE, 1'b1, BASE + 32'd3);
    checkOutput("gl_word3", vga_data, 32'hA3);
    applyStimulus(VGA_PRE, 1'b0, 32'd0);

    // No ack: timeout aborts the fetch and sets the sticky error
    ackEn = 1'b0;
    applyStimulus(VGA_INACTIVE, 1'b0, 32'd0);
    tick();
    applyStimulus(VGA_PRE, 1'b0, 32'd0);
    tick();
    tick();
    checkBit("to_stb", wb_stb_o, 1'b1);
    n = 0;
    while (fetch_err !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checkBit("to_err", fetch_err, 1'b1);
    checkBit("to_window", (n >= 250) && (n <= 260), 1'b1);
    checkBit("to_cyc", wb_cyc_o, 1'b0);
    checkBit("to_stb_low", wb_stb_o, 1'b0);
    checkBit("to_busreq", bus_req, 1'b0);
    applyStimulus(VGA_PRE, 1'b1, BASE);
    checkBit("to_invalid_busy", vga_busy, 1'b1);
    checkOutput("to_invalid_data", vga_data, 32'd0);
    applyStimulus(VGA_PRE, 1'b0, 32'd0);
    ackEn = 1'b1;
    applyStimulus(VGA_INACTIVE, 1'b0, 32'd0);
    tick();
    checkBit("to_sticky", fetch_err, 1'b1);
    applyStimulus(VGA_PRE, 1'b0, 32'd0);
    tick();
    checkBit("to_cleared", fetch_err, 1'b0);
    expectLine("rec", 0);
    tick();

    // Out-of-range and partial byte-select requests miss without fetching
    applyStimulus(VGA_PRE, 1'b1, BASE - 32'd1);
    checkBit("below_busy", vga_busy, 1'b1);
    checkOutput("below_data", vga_data, 32'd0);
    tick();
    checkBit("below_nofetch", bus_req, 1'b0);
    applyStimulus(VGA_PRE, 1'b1, BASE + 32'd384);
    checkBit("above_busy", vga_busy, 1'b1);
    tick();
    checkBit("above_nofetch", bus_req, 1'b0);
    vga_byte_sel = 4'h3;
    applyStimulus(VGA_PRE, 1'b1, BASE + 32'd1);
    checkBit("sel_busy", vga_busy, 1'b1);
    checkOutput("sel_data", vga_data, 32'd0);
    tick();
    checkBit("sel_nofetch", bus_req, 1'b0);
    vga_byte_sel = 4'hF;
    applyStimulus(VGA_PRE, 1'b1, BASE + 32'd1);
    checkOutput("sel_ok_data", vga_data, 32'hA1);

    // Last line loaded, then falling data_en wraps the prefetch to line 0
    applyStimulus(VGA_PRE, 1'b1, BASE + 32'd381);
    tick();
    expectLine("l95", 95);
    tick();
    checkOutput("l95_hit_data", vga_data, 32'h0000_021D);
    applyStimulus(VGA_ACTIVE, 1'b0, 32'd0);
    tick();
    checkBit("wrap_busreq", bus_req, 1'b1);
    expectLine("wrap", 0);
    tick();

    // Asynchronous reset in the middle of a read
    ackEn = 1'b0;
    applyStimulus(VGA_INACTIVE, 1'b0, 32'd0);
    tick();
    applyStimulus(VGA_PRE, 1'b0, 32'd0);
    tick();
    tick();
    checkBit("mid_cyc", wb_cyc_o, 1'b1);
    nrst = 1'b0;
    #1;
    checkAllZero("rst_mid");
    @(negedge clk);
    nrst = 1'b1;
    tick();
    applyStimulus(VGA_PRE, 1'b1, BASE);
    checkBit("rst_invalid_busy", vga_busy, 1'b1);
    checkOutput("rst_invalid_data", vga_data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/vga_line_fetcher.md
Name: vga_line_fetcher

Overview:
Sits between the VGA output stage and the Wishbone/IO arbitration layer. It prefetches one display line of frame-buffer words from SRAM into a small local line buffer while the VGA output stage is not consuming pixels. It then answers the VGA stage's per-pixel word requests from that buffer with zero added latency. On a buffer miss it raises busy and starts a demand fetch.

Parameters:
BASE_WORD_ADDR, 32'h0000_3E80, SRAM word address of frame-buffer line 0
LINE_WORDS, 4, 32-bit words per display line; power of 2, range 2..16
NUM_LINES, 96, display lines per frame; the line index wraps to 0 after NUM_LINES-1
CLIENT_ID, 2'd1, arbiter client code that grants this block the bus
TIMEOUT, 8'd255, maximum cycles to wait for ack before aborting a fetch

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
vga_state  in  2  0 = inactive, 1 = about to be active, 2 = active (from VGA output stage)
vga_data_en  in  1  pixel request valid
vga_word_addr  in  32  requested SRAM word address
vga_byte_sel  in  4  requested bytes; only 4'hF is supported
vga_data  out  32  returned word; 0 when not a hit
vga_busy  out  1  1 = requested word not available this cycle
current_client  in  2  arbiter grant code
bus_req  out  1  request for bus ownership
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  always 0
wb_adr_o  out  32  word address
wb_sel_o  out  4  4'hF while wb_stb_o is high, else 0
wb_dat_i  in  32  read data
wb_ack_i  in  1  read acknowledge
fetch_err  out  1  sticky timeout flag; cleared by reset or at frame start

Behaviour:
- Reset values: every output is 0. The FSM goes to IDLE, line_valid=0, line_tag=0, next_line=0, all buffer words=0.
- Hit path is combinational:
  - hit = vga_data_en & line_valid & (vga_word_addr - BASE_WORD_ADDR)/LINE_WORDS == line_tag.
  - vga_data = buf[addr offset mod LINE_WORDS] on hit, else 0.
  - vga_busy = vga_data_en & ~hit.
  - An address below BASE_WORD_ADDR, or a line index >= NUM_LINES, is a miss and triggers no fetch. In that case vga_busy=1 and vga_data=0.
- Fetch triggers (evaluated only in IDLE; priority order):
  1. vga_state becomes 2'b01 from any other value: next_line=0, fetch line 0, clear fetch_err.
  2. Miss with an in-range address: fetch that line (demand fetch).
  3. Falling edge of vga_data_en while vga_state==2'b10: fetch next_line, where next_line = (line_tag+1) mod NUM_LINES.
- A trigger that occurs while a fetch is already running is dropped, not queued. Any miss re-triggers the fetch once the FSM returns to IDLE.
- FSM states and transitions:
  - IDLE: go to REQ on a trigger. Latch target tag, set word counter=0, line_valid=0.
  - REQ: bus_req=1. When current_client==CLIENT_ID, go to READ the next cycle.
  - READ: cyc=stb=1, adr = BASE_WORD_ADDR + tag*LINE_WORDS + counter.
    - On wb_ack_i: write buf[counter]=wb_dat_i and increment counter. On the last word go to DONE; otherwise stb stays high for the next word (back-to-back reads are allowed).
    - If current_client no longer equals CLIENT_ID before ack: drop cyc/stb and return to REQ. Completed words are kept; the fetch resumes at the current counter.
  - DONE: line_tag=target, line_valid=1, drop cyc/stb/bus_req, return to IDLE. The hit is visible on the following cycle.
- Timeout: a cycle counter resets on every ack and on entry to READ. When it reaches TIMEOUT in READ: set fetch_err=1, line_valid=0, return to IDLE.
- An ack received outside READ is ignored.
- Best-case fetch latency: 1 (REQ) + LINE_WORDS acks + 1 (DONE), i.e. 6 cycles for LINE_WORDS=4 with an immediate grant and single-cycle acks.
- Asynchronous reset during a fetch aborts immediately. All bus outputs drop in the same instant and the buffer is invalid.
- vga_byte_sel != 4'hF with vga_data_en=1 is treated as a miss without a fetch.

Decomposition:
- Shared package vga_pkg holds: the fetch FSM enum (IDLE, REQ, READ, DONE), the VGA_state codes (INACTIVE=0, PRE=1, ACTIVE=2), and the client codes (CPU=0, VGA=1, UART=2).
- One sub-module, vga_line_buf: a LINE_WORDS x 32 register file with one synchronous write port and one combinational read port.

Test Plan:
- vga_state goes 0->1, grant immediate, ack every cycle with data 0xA0+n -> wb_adr_o = BASE..BASE+3, line_valid after 6 cycles; vga_word_addr=BASE+2 returns 0xA2 with busy=0.
- Line 0 loaded; data_en falls while vga_state=2 -> fetch of line 1 at BASE+4..BASE+7; a request for BASE+5 then hits.
- Cold buffer, request BASE+9 -> busy=1, data=0, demand fetch of line 2 (BASE+8..11); busy drops the cycle after DONE.
- Grant withdrawn after the 2nd ack, restored 5 cycles later -> reads resume at BASE+2; buffer words 0 and 1 are unchanged.
- No ack for 255 cycles -> fetch_err=1, cyc/stb=0, line_valid=0; the next vga_state 0->1 clears fetch_err.
- Line index 95 loaded, data_en falls -> the next fetch targets line 0 (wrap). nrst pulsed mid-READ -> all outputs 0.
